cv32e40px_apu_resp_model: RTL and testbench
===========================================

Name: cv32e40px_apu_resp_model

Overview:
- Synthesizable single-issue APU responder for the core's APU request/response port.
- Accepts one request at a time through a req/gnt handshake and computes an integer result after an op-dependent latency.
- Returns the result as a one-cycle valid pulse together with the destination register address. This is exactly the writeback stream consumed by the APU trace logger.
- Used in FPGA/simulation builds without a real FPU, and as a deterministic target for verifying core APU stall and writeback logic.

Parameters:
- ADD_LAT, 2, cycles from accept to rvalid for ops 0, 1 and illegal ops; legal range 1..15.
- MUL_LAT, 4, cycles from accept to rvalid for ops 2, 3 and 4; legal range 1..15.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- apu_req_i  input  1  request valid; held high by the core until granted.
- apu_gnt_o  output  1  grant; accept occurs when apu_req_i && apu_gnt_o.
- apu_op_i  input  6  operation code.
- apu_operand_a_i  input  32  operand A.
- apu_operand_b_i  input  32  operand B.
- apu_operand_c_i  input  32  operand C.
- apu_waddr_i  input  6  destination register; values 0..31 are x regs, 32..63 are f regs.
- apu_rvalid_o  output  1  one-cycle result pulse.
- apu_result_o  output  32  result.
- apu_waddr_o  output  6  destination register of the returned result.
- apu_rflags_o  output  5  bit0 = illegal op, bit1 = result zero, bits 4:2 = 0.
- busy_o  output  1  high while an operation is in flight (state BUSY).

Behaviour:
- Reset (rst_i = 1, asynchronous): state IDLE, counter 0; apu_rvalid_o, apu_result_o, apu_waddr_o, apu_rflags_o, busy_o all 0; apu_gnt_o is 0 while rst_i is high.
- Reset mid-operation: the in-flight op is discarded; no rvalid is ever produced for it.
- States: IDLE and BUSY. A 4-bit down-counter cnt is used only in BUSY.
- Grant is combinational: apu_gnt_o = apu_req_i && !rst_i && (state == IDLE || (state == BUSY && cnt == 0)).
- Accept: operands, op and waddr are sampled only on the accept edge.
  - The result and flags are computed and stored at that edge.
  - cnt <= LAT-1, where LAT is selected by op class; state <= BUSY.
- BUSY with cnt != 0: cnt decrements each cycle; the grant stays low.
- BUSY with cnt == 0: at the next edge apu_rvalid_o <= 1 and the stored result, waddr and flags are driven.
  - If no accept occurs in the same cycle, state <= IDLE.
  - If a new request is accepted in the same cycle, state stays BUSY and cnt is reloaded for the new op (back-to-back issue).
- Latency: accept at edge T gives apu_rvalid_o high for exactly the cycle following edge T+LAT.
  - Maximum throughput is one op per LAT cycles.
  - With LAT = 1, one op is accepted and returned every cycle.
- apu_rvalid_o is a single-cycle pulse with no backpressure; the core always accepts writeback.
- apu_result_o, apu_waddr_o and apu_rflags_o hold their last driven values while apu_rvalid_o is 0.
- Ops, all arithmetic modulo 2^32 and unsigned unless stated:
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 MUL: low 32 bits of a*b
  - 3 MAC: low 32 bits of a*b+c
  - 4 MULHU: high 32 bits of the unsigned 64-bit a*b
  - 5..63: illegal; result = a, rflags bit0 = 1, ADD_LAT latency.
- rflags bit1 = 1 iff the result equals 0, including illegal ops where a = 0.
- A request that arrives while the grant is low is not sampled. The core must hold op, operands and waddr stable until the grant.
- apu_waddr_o is passed through unchanged, including bit 5 (f/x select).

Test Plan:
- Reset, then ADD a=5, b=7, waddr=6'd3 accepted at edge T (ADD_LAT=2) -> rvalid pulse in the cycle after T+2; result=12, waddr=3, rflags=0; gnt low while BUSY with cnt != 0.
- SUB a=1, b=1, waddr=6'd40 -> result=0, rflags=5'b00010, waddr_o=40; then MULHU a=b=0xFFFF_FFFF -> result=0xFFFF_FFFE after exactly 4 cycles.
- MAC a=0x10000, b=0x10000, c=3 with req held high continuously, followed by MUL a=3, b=4 -> MAC result=3, then MUL result=12; the second accept occurs in the MAC completion cycle, so the rvalid pulses are 4 cycles apart with no idle gap.
- Illegal op 6'd9, a=0xDEAD_BEEF -> result=0xDEAD_BEEF, rflags=5'b00001, latency ADD_LAT.
- rst_i asserted 1 cycle after a MUL accept, then released -> no rvalid ever produced; all outputs read 0 during reset; the next ADD 1+1 returns 2 with normal latency.
- ADD_LAT=1, MUL_LAT=1 build: req held high for 8 cycles with varying ops -> gnt high every cycle; 8 consecutive rvalid pulses, each carrying the matching result and waddr in order.

Source files
------------

// File: rtl/cv32e40px_apu_resp_model.sv
// Single-issue APU responder: accepts one request at a time and returns an
// integer result with its destination register after an op-dependent latency.
module cv32e40px_apu_resp_model #(
  parameter int unsigned ADD_LAT = 2,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        apu_req_i,
  output logic        apu_gnt_o,
  input  logic [5:0]  apu_op_i,
  input  logic [31:0] apu_operand_a_i,
  input  logic [31:0] apu_operand_b_i,
  input  logic [31:0] apu_operand_c_i,
  input  logic [5:0]  apu_waddr_i,
  output logic        apu_rvalid_o,
  output logic [31:0] apu_result_o,
  output logic [5:0]  apu_waddr_o,
  output logic [4:0]  apu_rflags_o,
  output logic        busy_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] ADD_CNT = 4'(ADD_LAT - 1);
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [3:0]  lat_cnt;
  logic        done;
  logic        accept;
  logic        illegal;
  logic [63:0] prod;
  logic [31:0] res_calc;
  logic [4:0]  flags_calc;
  logic [31:0] res_reg;
  logic [5:0]  waddr_reg;
  logic [4:0]  flags_reg;

  // The completion cycle doubles as a grant cycle so ops can issue back to back.
  assign done      = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign apu_gnt_o = apu_req_i && !rst_i && ((state_reg == IDLE) || done);
  assign accept    = apu_req_i && apu_gnt_o;
  assign busy_o    = (state_reg == BUSY);

  assign prod = 64'(apu_operand_a_i) * 64'(apu_operand_b_i);

  always_comb begin
    res_calc = apu_operand_a_i;
    illegal  = 1'b0;
    lat_cnt  = ADD_CNT;
    case (apu_op_i)
      6'd0: res_calc = apu_operand_a_i + apu_operand_b_i;
      6'd1: res_calc = apu_operand_a_i - apu_operand_b_i;
      6'd2: begin
        res_calc = prod[31:0];
        lat_cnt  = MUL_CNT;
      end
      6'd3: begin
        res_calc = prod[31:0] + apu_operand_c_i;
        lat_cnt  = MUL_CNT;
      end
      6'd4: begin
        res_calc = prod[63:32];
        lat_cnt  = MUL_CNT;
      end
      default: illegal = 1'b1;
    endcase
    flags_calc = {3'b000, (res_calc == 32'd0), illegal};
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (accept) begin
      state_next = BUSY;
      cnt_next   = lat_cnt;
    end else if (state_reg == BUSY) begin
      if (cnt_reg != 4'd0) cnt_next = cnt_reg - 4'd1;
      else                 state_next = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Result is captured at accept so inputs need only be stable until the grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_reg      <= 32'd0;
      waddr_reg    <= 6'd0;
      flags_reg    <= 5'd0;
      apu_rvalid_o <= 1'b0;
      apu_result_o <= 32'd0;
      apu_waddr_o  <= 6'd0;
      apu_rflags_o <= 5'd0;
    end else begin
      apu_rvalid_o <= done;
      if (done) begin
        apu_result_o <= res_reg;
        apu_waddr_o  <= waddr_reg;
        apu_rflags_o <= flags_reg;
      end
      if (accept) begin
        res_reg   <= res_calc;
        waddr_reg <= apu_waddr_i;
        flags_reg <= flags_calc;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40px_apu_resp_model.sv
// Bench for cv32e40px_apu_resp_model: a default-latency instance and a
// single-cycle instance, both checked every cycle against a timing/value model.
module tb_cv32e40px_apu_resp_model;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req    [2];
  logic        gnt    [2];
  logic [5:0]  op     [2];
  logic [31:0] opa    [2];
  logic [31:0] opb    [2];
  logic [31:0] opc    [2];
  logic [5:0]  waddr  [2];
  logic        rvalid [2];
  logic [31:0] result [2];
  logic [5:0]  waddr_o[2];
  logic [4:0]  rflags [2];
  logic        busy   [2];

  int n_checks = 0;
  int n_fail   = 0;
  int ecount   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ecount = ecount + 1;

  cv32e40px_apu_resp_model #(.ADD_LAT(2), .MUL_LAT(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .apu_req_i(req[0]), .apu_gnt_o(gnt[0]),
    .apu_op_i(op[0]), .apu_operand_a_i(opa[0]), .apu_operand_b_i(opb[0]),
    .apu_operand_c_i(opc[0]), .apu_waddr_i(waddr[0]), .apu_rvalid_o(rvalid[0]),
    .apu_result_o(result[0]), .apu_waddr_o(waddr_o[0]), .apu_rflags_o(rflags[0]),
    .busy_o(busy[0])
  );

  cv32e40px_apu_resp_model #(.ADD_LAT(1), .MUL_LAT(1)) u_dut_fast (
    .clk_i(clk), .rst_i(rst), .apu_req_i(req[1]), .apu_gnt_o(gnt[1]),
    .apu_op_i(op[1]), .apu_operand_a_i(opa[1]), .apu_operand_b_i(opb[1]),
    .apu_operand_c_i(opc[1]), .apu_waddr_i(waddr[1]), .apu_rvalid_o(rvalid[1]),
    .apu_result_o(result[1]), .apu_waddr_o(waddr_o[1]), .apu_rflags_o(rflags[1]),
    .busy_o(busy[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int idx, input logic [5:0] o);
    if (idx == 1) return 1;
    return (o >= 6'd2 && o <= 6'd4) ? 4 : 2;
  endfunction

  function automatic logic [31:0] ref_result(input logic [5:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] c);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    case (o)
      6'd0: return a + b;
      6'd1: return a - b;
      6'd2: return p[31:0];
      6'd3: return 32'((p + longint'(c)) & 64'hFFFF_FFFF);
      6'd4: return p[63:32];
      default: return a;
    endcase
  endfunction

  typedef struct {
    int          due;
    logic [31:0] res;
    logic [5:0]  wa;
    logic [4:0]  fl;
  } exp_t;

  exp_t        ring     [2][4];
  int          hd       [2];
  int          tl       [2];
  int          free_edge[2];
  logic [31:0] h_res    [2];
  logic [5:0]  h_wa     [2];
  logic [4:0]  h_fl     [2];

  // Model: an op accepted at edge T owns the unit until edge T+LAT and its
  // result appears in the cycle after edge T+LAT.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        check($sformatf("d%0d_rst_gnt", i), 64'(gnt[i]), 64'd0);
        check($sformatf("d%0d_rst_rvalid", i), 64'(rvalid[i]), 64'd0);
        check($sformatf("d%0d_rst_result", i), 64'(result[i]), 64'd0);
        check($sformatf("d%0d_rst_waddr", i), 64'(waddr_o[i]), 64'd0);
        check($sformatf("d%0d_rst_flags", i), 64'(rflags[i]), 64'd0);
        check($sformatf("d%0d_rst_busy", i), 64'(busy[i]), 64'd0);
        hd[i] = 0; tl[i] = 0; free_edge[i] = 0;
        h_res[i] = '0; h_wa[i] = '0; h_fl[i] = '0;
      end else begin
        logic rv_exp, gnt_exp;
        int   l;
        rv_exp = (tl[i] != hd[i]) && (ring[i][hd[i] % 4].due == ecount);
        if (rv_exp) begin
          h_res[i] = ring[i][hd[i] % 4].res;
          h_wa[i]  = ring[i][hd[i] % 4].wa;
          h_fl[i]  = ring[i][hd[i] % 4].fl;
          hd[i]++;
          $display("[d%0d] rsp edge=%0d waddr=%0d result=0x%08h flags=%05b",
                   i, ecount, h_wa[i], h_res[i], h_fl[i]);
        end
        check($sformatf("d%0d_rvalid", i), 64'(rvalid[i]), 64'(rv_exp));
        check($sformatf("d%0d_result", i), 64'(result[i]), 64'(h_res[i]));
        check($sformatf("d%0d_waddr", i), 64'(waddr_o[i]), 64'(h_wa[i]));
        check($sformatf("d%0d_flags", i), 64'(rflags[i]), 64'(h_fl[i]));
        check($sformatf("d%0d_busy", i), 64'(busy[i]), 64'(ecount < free_edge[i]));
        gnt_exp = req[i] && (ecount + 1 >= free_edge[i]);
        check($sformatf("d%0d_gnt", i), 64'(gnt[i]), 64'(gnt_exp));
        if (gnt_exp) begin
          exp_t e;
          l = lat_of(i, op[i]);
          e.due = ecount + 1 + l;
          e.res = ref_result(op[i], opa[i], opb[i], opc[i]);
          e.wa  = waddr[i];
          e.fl  = {3'b000, (e.res == 32'd0), (op[i] > 6'd4)};
          ring[i][tl[i] % 4] = e;
          tl[i]++;
          free_edge[i] = ecount + 1 + l;
          $display("[d%0d] req edge=%0d op=%0d a=0x%08h b=0x%08h c=0x%08h waddr=%0d",
                   i, ecount + 1, op[i], opa[i], opb[i], opc[i], waddr[i]);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Called at posedge+2; returns at posedge+2 just after the accept edge.
  task automatic issue(input int idx, input logic [5:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c,
                       input logic [5:0] wa, input bit hold);
    bit granted = 0;
    req[idx] = 1'b1; op[idx] = o; opa[idx] = a; opb[idx] = b; opc[idx] = c; waddr[idx] = wa;
    for (int n = 0; n < 40 && !granted; n++) begin
      @(negedge clk);
      if (gnt[idx]) granted = 1;
      @(posedge clk);
      #2;
    end
    if (!granted) check("gnt_timeout", 64'd0, 64'd1);
    if (!hold || !granted) req[idx] = 1'b0;
  endtask

  task automatic rand_issue(input int idx, input bit hold);
    logic [5:0]  o;
    logic [31:0] a, b;
    o = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(5, 63)) : 6'($urandom_range(0, 4));
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
    if ($urandom_range(0, 7) == 0) a = 32'd0;
    issue(idx, o, a, b, $urandom, 6'($urandom), hold);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; op[i] = 0; opa[i] = 0; opb[i] = 0; opc[i] = 0; waddr[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    idle(1);

    issue(0, 6'd0, 32'd5, 32'd7, 32'd0, 6'd3, 0);
    idle(4);
    check("add_5_7_result", 64'(result[0]), 64'd12);
    check("add_5_7_waddr", 64'(waddr_o[0]), 64'd3);

    issue(0, 6'd1, 32'd1, 32'd1, 32'd0, 6'd40, 0);
    idle(3);
    check("sub_zero_flags", 64'(rflags[0]), 64'b00010);
    check("sub_zero_waddr", 64'(waddr_o[0]), 64'd40);
    issue(0, 6'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 6'd7, 0);
    idle(5);
    check("mulhu_result", 64'(result[0]), 64'hFFFF_FFFE);

    issue(0, 6'd3, 32'h0001_0000, 32'h0001_0000, 32'd3, 6'd10, 1);
    issue(0, 6'd2, 32'd3, 32'd4, 32'd0, 6'd11, 0);
    idle(6);
    check("mul_after_mac", 64'(result[0]), 64'd12);

    issue(0, 6'd9, 32'hDEAD_BEEF, 32'd1, 32'd2, 6'd33, 0);
    idle(3);
    check("illegal_result", 64'(result[0]), 64'hDEAD_BEEF);
    check("illegal_flags", 64'(rflags[0]), 64'b00001);

    issue(0, 6'd2, 32'd6, 32'd7, 32'd0, 6'd12, 0);
    idle(1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(6);
    issue(0, 6'd0, 32'd1, 32'd1, 32'd0, 6'd13, 0);
    idle(3);
    check("add_after_rst", 64'(result[0]), 64'd2);

    for (int k = 0; k < 8; k++)
      issue(1, 6'(k % 6), 32'(k * 3 + 1), 32'(k + 2), 32'(k), 6'(k + 20), k != 7);
    idle(3);
    check("fast_last_waddr", 64'(waddr_o[1]), 64'd27);

    for (int k = 0; k < 60; k++) begin
      rand_issue(0, $urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 5));
    end
    req[0] = 1'b0;
    for (int k = 0; k < 60; k++) begin
      rand_issue(1, $urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
    end
    req[1] = 1'b0;
    idle(10);
    check("d0_drained", 64'(tl[0] - hd[0]), 64'd0);
    check("d1_drained", 64'(tl[1] - hd[1]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
